// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the ordered reset-release sequencer.
// Imported by reset_sequencer and anything that needs its state encoding.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD         = 2'd0,
    ST_RELEASE_WAIT = 2'd1,
    ST_RUN          = 2'd2,
    ST_ASSERT       = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_STAGES    = 3;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_STAGE_GAP     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Wide enough to hold the larger of the hold and timeout counts.
  function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
    int m;
    m = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds every domain in reset, releases them
// lowest index first with a gap and ready/timeout handshake, and supports warm reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  all_done,
  output logic                  busy,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] timeout_err
);

  localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int IW = idx_width(NUM_STAGES);

  localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);
  localparam logic [CW:0]   GAP_VAL  = (CW+1)'(STAGE_GAP);
  localparam logic [CW:0]   TMO_VAL  = (CW+1)'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

  seq_state_t            state_reg;
  logic [CW-1:0]         counter_reg;
  logic [IW-1:0]         idx_reg;
  logic [NUM_STAGES-1:0] stage_resetn_reg;
  logic [NUM_STAGES-1:0] timeout_err_reg;
  logic                  all_done_reg;
  logic                  busy_reg;
  logic                  soft_ack_reg;
  logic                  warm_reg;

  logic [CW-1:0] counter_next;
  logic [CW:0]   cnt_plus1;
  logic          ready_ok;
  logic          timed_out;

  // Saturating increment; the counter never wraps back into a valid window.
  always_comb begin
    counter_next = (counter_reg == CNT_MAX) ? counter_reg : counter_reg + 1'b1;
    cnt_plus1    = {1'b0, counter_reg} + {{CW{1'b0}}, 1'b1};
    ready_ok     = (cnt_plus1 >= GAP_VAL) && stage_ready[idx_reg];
    timed_out    = (cnt_plus1 == TMO_VAL);
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_reg        <= ST_HOLD;
      counter_reg      <= '0;
      idx_reg          <= '0;
      stage_resetn_reg <= '0;
      timeout_err_reg  <= '0;
      all_done_reg     <= 1'b0;
      busy_reg         <= 1'b1;
      soft_ack_reg     <= 1'b0;
      warm_reg         <= 1'b0;
    end else begin
      soft_ack_reg <= 1'b0;
      unique case (state_reg)
        ST_HOLD: begin
          if (counter_reg == HOLD_VAL) begin
            stage_resetn_reg[0] <= 1'b1;
            idx_reg             <= '0;
            counter_reg         <= '0;
            state_reg           <= ST_RELEASE_WAIT;
          end else begin
            counter_reg <= counter_next;
          end
        end

        ST_RELEASE_WAIT: begin
          if (ready_ok || timed_out) begin
            // Ready wins when it coincides with the timeout edge.
            if (!ready_ok) begin
              timeout_err_reg[idx_reg] <= 1'b1;
            end
            if (idx_reg == LAST_IDX) begin
              state_reg    <= ST_RUN;
              all_done_reg <= 1'b1;
              busy_reg     <= 1'b0;
              if (warm_reg) begin
                soft_ack_reg <= 1'b1;
                warm_reg     <= 1'b0;
              end
            end else begin
              stage_resetn_reg[idx_reg + 1'b1] <= 1'b1;
              idx_reg                          <= idx_reg + 1'b1;
              counter_reg                      <= '0;
            end
          end else begin
            counter_reg <= counter_next;
          end
        end

        ST_RUN: begin
          if (soft_req && !soft_ack_reg) begin
            all_done_reg                   <= 1'b0;
            busy_reg                       <= 1'b1;
            warm_reg                       <= 1'b1;
            stage_resetn_reg[NUM_STAGES-1] <= 1'b0;
            if (NUM_STAGES == 1) begin
              state_reg   <= ST_HOLD;
              counter_reg <= '0;
              idx_reg     <= '0;
            end else begin
              state_reg <= ST_ASSERT;
              idx_reg   <= LAST_IDX;
            end
          end
        end

        ST_ASSERT: begin
          // idx_reg names the stage cleared last; clear the one below it.
          stage_resetn_reg[idx_reg - 1'b1] <= 1'b0;
          idx_reg                          <= idx_reg - 1'b1;
          if (idx_reg == IW'(1)) begin
            state_reg   <= ST_HOLD;
            counter_reg <= '0;
            idx_reg     <= '0;
          end
        end

        default: begin
          state_reg <= ST_HOLD;
        end
      endcase
    end
  end

  assign stage_resetn = stage_resetn_reg;
  assign all_done     = all_done_reg;
  assign busy         = busy_reg;
  assign soft_ack     = soft_ack_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: table-driven release timing checks plus
// hand-written warm-reset and mid-sequence reset sequences.
module tb_reset_sequencer;

  logic       clk;
  logic       reset_in;
  logic [2:0] stage_ready;
  logic       soft_req;
  logic [2:0] stage_resetn;
  logic       all_done;
  logic       busy;
  logic       soft_ack;
  logic [2:0] timeout_err;

  reset_sequencer #(
    .NUM_STAGES    (3),
    .HOLD_CYCLES   (16),
    .STAGE_GAP     (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .stage_ready (stage_ready),
    .soft_req    (soft_req),
    .stage_resetn(stage_resetn),
    .all_done    (all_done),
    .busy        (busy),
    .soft_ack    (soft_ack),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         scen;
    int         edge_n;
    logic [2:0] rn;
    logic       ad;
    logic       bz;
    logic       sa;
    logic [2:0] te;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_pass;
  int   cur_edge;

  task automatic step();
    @(posedge clk);
    #1;
    cur_edge++;
  endtask

  task automatic chk(input string nm, input logic [2:0] rn, input logic ad,
                     input logic bz, input logic sa, input logic [2:0] te);
    n_checks++;
    if ({stage_resetn, all_done, busy, soft_ack, timeout_err} !== {rn, ad, bz, sa, te}) begin
      $display("FAIL %s: got resetn=%b done=%b busy=%b ack=%b terr=%b, want resetn=%b done=%b busy=%b ack=%b terr=%b",
               nm, stage_resetn, all_done, busy, soft_ack, timeout_err, rn, ad, bz, sa, te);
    end else begin
      n_pass++;
      $display("check %s ok: resetn=%b done=%b busy=%b ack=%b terr=%b",
               nm, stage_resetn, all_done, busy, soft_ack, timeout_err);
    end
  endtask

  task automatic check_table(input int scen, input int e);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen && vecs[i].edge_n == e) begin
        chk($sformatf("s%0d_E%0d", scen, e), vecs[i].rn, vecs[i].ad, vecs[i].bz,
            vecs[i].sa, vecs[i].te);
      end
    end
  endtask

  task automatic do_reset(input logic [2:0] ready0);
    reset_in    = 1'b1;
    soft_req    = 1'b0;
    stage_ready = ready0;
    repeat (5) step();
    chk("reset_state", 3'b000, 1'b0, 1'b1, 1'b0, 3'b000);
    reset_in = 1'b0;
    cur_edge = -1;
  endtask

  // late_edge: edge at which ready becomes 3'b111 (-1 = never);
  // soft_req is held high for edges soft_lo..soft_hi.
  task automatic run_scen(input int scen, input int last_edge, input logic [2:0] ready0,
                          input int late_edge, input int soft_lo, input int soft_hi);
    do_reset(ready0);
    soft_req = (soft_lo <= 0 && soft_hi >= 0);
    while (cur_edge < last_edge) begin
      step();
      check_table(scen, cur_edge);
      if (late_edge >= 0 && cur_edge + 1 >= late_edge) stage_ready = 3'b111;
      soft_req = (cur_edge + 1 >= soft_lo && cur_edge + 1 <= soft_hi);
    end
    soft_req = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    cur_edge    = 0;
    reset_in    = 1'b1;
    soft_req    = 1'b0;
    stage_ready = 3'b000;

    // Power-up, all ready.
    vecs.push_back('{1, 15, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 16, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 19, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 20, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 23, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 24, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 27, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{1, 28, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000});
    vecs.push_back('{1, 29, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000});
    // Late ready on stage 1 (first seen at E30).
    vecs.push_back('{2, 20, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{2, 29, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{2, 30, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{2, 33, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{2, 34, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000});
    // Stage 1 never ready: timeout at E84.
    vecs.push_back('{3, 83, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{3, 84, 3'b111, 1'b0, 1'b1, 1'b0, 3'b010});
    vecs.push_back('{3, 87, 3'b111, 1'b0, 1'b1, 1'b0, 3'b010});
    vecs.push_back('{3, 88, 3'b111, 1'b1, 1'b0, 1'b0, 3'b010});
    // soft_req during HOLD/RELEASE_WAIT must be ignored.
    vecs.push_back('{6, 16, 3'b001, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{6, 20, 3'b011, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{6, 24, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{6, 27, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{6, 28, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000});
    vecs.push_back('{6, 29, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000});

    run_scen(1, 29, 3'b111, -1, 1000, -1);
    run_scen(2, 34, 3'b101, 30, 1000, -1);
    run_scen(3, 88, 3'b101, -1, 1000, -1);

    // Warm reset from RUN; timeout_err=010 must survive it.
    stage_ready = 3'b111;
    step();
    step();
    soft_req = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      step();
      case (k)
        0:  chk("warm_S",    3'b011, 1'b0, 1'b1, 1'b0, 3'b010);
        1:  chk("warm_S+1",  3'b001, 1'b0, 1'b1, 1'b0, 3'b010);
        2:  chk("warm_S+2",  3'b000, 1'b0, 1'b1, 1'b0, 3'b010);
        18: chk("warm_S+18", 3'b000, 1'b0, 1'b1, 1'b0, 3'b010);
        19: chk("warm_S+19", 3'b001, 1'b0, 1'b1, 1'b0, 3'b010);
        23: chk("warm_S+23", 3'b011, 1'b0, 1'b1, 1'b0, 3'b010);
        27: chk("warm_S+27", 3'b111, 1'b0, 1'b1, 1'b0, 3'b010);
        30: chk("warm_S+30", 3'b111, 1'b0, 1'b1, 1'b0, 3'b010);
        31: chk("warm_S+31", 3'b111, 1'b1, 1'b0, 1'b1, 3'b010);
        32: chk("warm_S+32", 3'b111, 1'b1, 1'b0, 1'b0, 3'b010);
        33: chk("warm_S+33", 3'b111, 1'b1, 1'b0, 1'b0, 3'b010);
        default: ;
      endcase
      if (k == 32) soft_req = 1'b0;
    end

    // Second warm reset, then reset_in pulse at sequence edge E22.
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    for (int k = 1; k <= 24; k++) step();
    chk("warm2_E21", 3'b011, 1'b0, 1'b1, 1'b0, 3'b010);
    reset_in = 1'b1;
    step();
    chk("mid_reset", 3'b000, 1'b0, 1'b1, 1'b0, 3'b000);
    reset_in = 1'b0;
    cur_edge = -1;
    while (cur_edge < 29) begin
      step();
      check_table(1, cur_edge);
    end

    run_scen(6, 29, 3'b111, -1, 5, 27);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Ordered reset-release controller for the SoC.
- Holds all downstream reset domains in reset, then releases them one stage at a time, lowest index first, with a minimum gap between stages and a per-stage ready handshake with timeout.
- Supports a software-requested warm reset that re-asserts the stages in reverse order and re-runs the release sequence.
- Sits between the already-synchronised system reset and the per-block active-low resets (CPU, memory, Ascon core, peripherals).

Parameters:
- NUM_STAGES, 3: number of sequenced reset domains (≥1).
- HOLD_CYCLES, 16: cycles held in reset after reset_in deasserts, or after a warm-reset assert sweep, before stage 0 is released (≥1).
- STAGE_GAP, 4: minimum cycles between release of stage k and stage k+1 (≥1).
- TIMEOUT_CYCLES, 64: cycles after release of stage k after which the sequencer proceeds without stage_ready[k] (≥STAGE_GAP).

Ports:
- clk  in  1  system clock.
- reset_in  in  1  synchronous, active-high reset; must already be synchronous to clk.
- stage_ready  in  NUM_STAGES  per-stage "initialisation complete"; level, sampled only while waiting on that stage.
- soft_req  in  1  warm-reset request; level, sampled only in RUN.
- stage_resetn  out  NUM_STAGES  active-low reset per stage.
- all_done  out  1  high while every stage is released (state RUN).
- busy  out  1  high whenever state ≠ RUN.
- soft_ack  out  1  one-cycle pulse when a warm-reset sequence completes.
- timeout_err  out  NUM_STAGES  sticky; bit k set if stage k timed out.

Behaviour:
- Reset (reset_in=1 at an edge): state=HOLD, counter=0, idx=0, stage_resetn=0, all_done=0, busy=1, soft_ack=0, timeout_err=0, warm flag=0. reset_in mid-operation in any state gives exactly this on the next edge.
- States: HOLD, RELEASE_WAIT, RUN, ASSERT.
- HOLD:
  - Let E0 be the first edge with reset_in=0; counter increments each edge.
  - At edge E(HOLD_CYCLES): stage_resetn[0]=1, idx=0, counter=0, state=RELEASE_WAIT.
- RELEASE_WAIT (stage idx released, counter counts edges since release):
  - Advance on the first edge where counter+1 ≥ STAGE_GAP and stage_ready[idx]=1, or where counter+1 = TIMEOUT_CYCLES.
  - On a timeout advance, also set timeout_err[idx]. If ready and timeout coincide, treat as ready (no error).
  - Advance with idx<NUM_STAGES-1: stage_resetn[idx+1]=1, idx++, counter=0.
  - Advance with idx=NUM_STAGES-1: state=RUN, all_done=1, busy=0. If the warm flag is set: soft_ack=1 for that one cycle, then clear the warm flag.
- RUN:
  - soft_req is sampled only on cycles where soft_ack=0.
  - soft_req=1 at edge S: state=ASSERT, all_done=0, busy=1, warm flag=1, stage_resetn[NUM_STAGES-1]=0.
  - ASSERT clears one further stage per edge in descending index; stage 0 is cleared at edge S+NUM_STAGES-1.
  - The next edge is E0 of HOLD, with counter=0.
- soft_req outside RUN is ignored; no queuing.
- stage_resetn is monotonic within a sequence: never re-releases a stage out of order; bits above idx stay 0 during release.
- timeout_err is cleared only by reset_in; a warm reset preserves it.
- Counter width: $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1). The counter saturates and never wraps.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package reset_seq_pkg:
  - State enum (HOLD, RELEASE_WAIT, RUN, ASSERT).
  - Default parameter constants.
  - Counter-width function.
- No sub-module: a single FSM plus one counter and an index register.
- Instantiated once at SoC top; each stage_resetn bit drives one block's resetn.

Test Plan (NUM_STAGES=3, HOLD=16, GAP=4, TIMEOUT=64):
- Power-up, stage_ready=3'b111, reset_in high 5 cycles then low: stage_resetn=001 at E16, 011 at E20, 111 at E24, all_done=1 at E28, busy=0, soft_ack=0, timeout_err=000.
- Late ready, stage_ready[1] held 0 until sampled 1 at E30: stage_resetn=111 at E30, all_done at E34, timeout_err=000.
- Missing ready, stage_ready[1] stuck 0: stage_resetn=111 at E84 (E20+64), timeout_err=010, all_done at E88.
- Warm reset, soft_req=1 at edge S in RUN with all ready:
  - stage_resetn=011 at S, 001 at S+1, 000 at S+2.
  - 001 at S+19, 011 at S+23, 111 at S+27; all_done and a single-cycle soft_ack at S+31.
  - soft_req still high at S+31 is ignored; timeout_err unchanged.
- reset_in asserted one cycle at E22, during stage 1 wait: stage_resetn=000, all_done=0, timeout_err=000 on the next edge; the sequence restarts with the first edge with reset_in=0 as E0 and matches the power-up timing.
- soft_req=1 during HOLD and RELEASE_WAIT: no effect on the sequence; no soft_ack; all_done at E28 as in the power-up case.
